spike_rate_decoder: RTL
=======================

// Module: spike_rate_decoder
// PURPOSE
//  Receive end of the neuron spike interface. Samples the 1-bit spike train from an
//  LSNN neuron output bus and decodes it back to 8-bit values: spike count per fixed
//  window (rate code) and last inter-spike interval (ISI). The rate result leaves on a
//  valid/ready handshake for downstream readout or the next layer's input current.
// PARAMETERS
//  WINDOW   16   sampled cycles per rate window; legal range 2..256
// PORTS
//  clk         in   1  single clock; all state changes on posedge
//  rst_n       in   1  reset: asynchronous, active-high (1 = reset), despite the name
//  spike_in    in   8  neuron spike bus; bit0 = spike, bits 7:1 ignored
//  enable      in   1  1 = decode; 0 = idle, discard partial window
//  rate_ready  in   1  downstream accepts rate_out when high together with rate_valid
//  rate_out    out  8  spikes counted in last completed window (saturating)
//  rate_valid  out  1  rate_out holds an unaccepted result
//  isi_out     out  8  cycles between the two most recent spikes (saturating)
//  overrun     out  1  sticky: a completed window overwrote an unaccepted result
// BEHAVIOUR
//  Reset (async, any time, incl. mid-window): state=IDLE; rate_out, rate_valid,
//   isi_out, overrun, all internal counters and prev-spike flag = 0.
//  FSM: IDLE -> COUNT when enable=1 at a posedge; COUNT -> IDLE when enable=0 at a
//   posedge (partial window, ISI counter, prev-spike flag cleared; rate_out,
//   rate_valid, isi_out, overrun keep values). Reset is the only other transition.
//  COUNT samples spike_in[0] at every posedge, starting the first posedge after entry.
//  Window: win_cnt 0..WINDOW-1. On the sample with win_cnt==WINDOW-1, the same edge
//   loads rate_out <= sat255(spike_cnt + spike), sets rate_valid, clears spike_cnt
//   and win_cnt. Windows are back-to-back, no dead cycle; latency = 0 beyond window.
//  spike_cnt is 9-bit internally; result saturates at 255 (only WINDOW=256, all 1s).
//  Handshake: rate_valid stays 1 and rate_out stable until a posedge with
//   rate_valid & rate_ready, which clears rate_valid. rate_ready ignored when
//   rate_valid=0.
//  Simultaneous window completion and acceptance: new result loaded, rate_valid stays
//   1, overrun NOT set. Completion with rate_valid=1 and rate_ready=0: result
//   overwritten, rate_valid stays 1, overrun <= 1; overrun clears only on reset.
//  ISI: isi_cnt increments each COUNT sample without spike, saturates at 255. On a
//   spike sample: if prev-spike flag set, isi_out <= sat255(isi_cnt + 1); then
//   isi_cnt <= 0, flag <= 1. First spike after entering COUNT only sets the flag.
//   Consecutive spikes on adjacent samples give isi_out = 1.
//  Outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1. WINDOW=16, rate_ready=1, enable=1, spike every sample -> rate_valid 1-cycle pulse
//     every 16 cycles, first after 16th sample; rate_out=16; isi_out=1.
//  2. Spike every 4th sample, rate_ready=1 -> rate_out=4 each window; isi_out=4.
//  3. rate_ready=0 across two windows (3 spikes, then 5) -> rate_out=5, rate_valid=1,
//     overrun=1; rate_ready=1 one cycle -> rate_valid=0, overrun stays 1.
//  4. rate_valid=1 and rate_ready=1 on the completion edge -> new value loaded,
//     rate_valid stays 1, overrun stays 0.
//  5. enable dropped after 10 samples with 6 spikes -> no new result; re-enable, 16
//     samples with 2 spikes -> rate_out=2 (no carry-over); isi_out unchanged
//     until second spike after re-entry.
//  6. WINDOW=256 all spikes -> rate_out=255; 300 samples without spike then spike ->
//     isi_out=255; rst_n pulsed mid-window -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: receive side of the neuron spike interface.
// Samples bit 0 of the spike bus and recovers two 8-bit values from it:
//  - rate_out: spikes counted over a fixed window of WINDOW samples, delivered
//    on a valid/ready handshake (a newer window overwrites an unaccepted one
//    and raises the sticky overrun flag);
//  - isi_out: number of samples between the two most recent spikes.
// WINDOW legal range is 2..256. All outputs are registered.
module spike_rate_decoder #(
  parameter int WINDOW = 16
) (
  input  logic       clk,
  input  logic       rst_n,       // asynchronous, active-high reset despite the name
  input  logic [7:0] spike_in,
  input  logic       enable,
  input  logic       rate_ready,
  output logic [7:0] rate_out,
  output logic       rate_valid,
  output logic [7:0] isi_out,
  output logic       overrun
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Last window index; 9 bits so WINDOW=256 (index 255) fits with headroom.
  localparam logic [8:0] WIN_LAST = 9'(WINDOW - 1);

  // Clamp a 9-bit count into the 8-bit output range.
  function automatic logic [7:0] sat255(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

  // Increment an 8-bit counter, holding at 255.
  function automatic logic [7:0] inc_sat(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state_q,      state_d;
  logic [8:0] win_cnt_q,    win_cnt_d;
  logic [8:0] spike_cnt_q,  spike_cnt_d;
  logic [7:0] isi_cnt_q,    isi_cnt_d;
  logic       prev_spike_q, prev_spike_d;
  logic [7:0] rate_out_q,   rate_out_d;
  logic       rate_valid_q, rate_valid_d;
  logic [7:0] isi_out_q,    isi_out_d;
  logic       overrun_q,    overrun_d;

  logic       spike;
  logic [8:0] spike_sum;
  logic       unused_spike_bits;

  // Only bit 0 carries the spike; the upper bus bits are don't-care.
  assign spike             = spike_in[0];
  assign unused_spike_bits = ^spike_in[7:1];
  assign spike_sum         = spike_cnt_q + {8'd0, spike};

  // Next-state logic: FSM, window counting, handshake and ISI tracking.
  always_comb begin
    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    spike_cnt_d  = spike_cnt_q;
    isi_cnt_d    = isi_cnt_q;
    prev_spike_d = prev_spike_q;
    rate_out_d   = rate_out_q;
    rate_valid_d = rate_valid_q;
    isi_out_d    = isi_out_q;
    overrun_d    = overrun_q;

    // Acceptance is independent of the FSM state; a completion on the same
    // edge below re-asserts valid with the new result.
    if (rate_valid_q && rate_ready) begin
      rate_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d      = COUNT;
          win_cnt_d    = 9'd0;
          spike_cnt_d  = 9'd0;
          isi_cnt_d    = 8'd0;
          prev_spike_d = 1'b0;
        end
      end

      COUNT: begin
        if (!enable) begin
          // Leaving discards the partial window and ISI history; results stay.
          state_d      = IDLE;
          win_cnt_d    = 9'd0;
          spike_cnt_d  = 9'd0;
          isi_cnt_d    = 8'd0;
          prev_spike_d = 1'b0;
        end else begin
          if (win_cnt_q == WIN_LAST) begin
            // The closing sample itself is included in the published count.
            rate_out_d   = sat255(spike_sum);
            rate_valid_d = 1'b1;
            if (rate_valid_q && !rate_ready) begin
              overrun_d = 1'b1;
            end
            win_cnt_d   = 9'd0;
            spike_cnt_d = 9'd0;
          end else begin
            win_cnt_d   = win_cnt_q + 9'd1;
            spike_cnt_d = spike_sum;
          end

          if (spike) begin
            // The first spike after entry has no predecessor: only arm the flag.
            if (prev_spike_q) begin
              isi_out_d = sat255({1'b0, isi_cnt_q} + 9'd1);
            end
            isi_cnt_d    = 8'd0;
            prev_spike_d = 1'b1;
          end else begin
            isi_cnt_d = inc_sat(isi_cnt_q);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with asynchronous active-high clear of everything.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE;
      win_cnt_q    <= 9'd0;
      spike_cnt_q  <= 9'd0;
      isi_cnt_q    <= 8'd0;
      prev_spike_q <= 1'b0;
      rate_out_q   <= 8'd0;
      rate_valid_q <= 1'b0;
      isi_out_q    <= 8'd0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      spike_cnt_q  <= spike_cnt_d;
      isi_cnt_q    <= isi_cnt_d;
      prev_spike_q <= prev_spike_d;
      rate_out_q   <= rate_out_d;
      rate_valid_q <= rate_valid_d;
      isi_out_q    <= isi_out_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rate_out   = rate_out_q;
  assign rate_valid = rate_valid_q;
  assign isi_out    = isi_out_q;
  assign overrun    = overrun_q;

endmodule
